checkout_tally: RTL and testbench

Sequential checkout accumulator for the department-store design on the DE1-SoC. It takes a 3-bit item UPC from the switches and a scan strobe from a push-key, and looks the item up in a fixed price table. It adds the price to a running 4-digit BCD total (dollars.cents) using a digit-serial adder. It sits directly upstream of the seg7 decoders: each BCD digit of `total_bcd` and the item count drive one HEX display.

---
 rtl/checkout_tally.sv | 146 ++++++++++++++
 tb/tb_checkout_tally.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/checkout_tally.sv
// Checkout accumulator: a scan looks up a fixed item price, which is added
// into a 4-digit BCD running total one digit per cycle; clear zeroes everything.
`timescale 1ns/1ps
module checkout_tally #(
  parameter int CNT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  upc,
  input  logic        scan,
  input  logic        clear,
  output logic [15:0] total_bcd,
  output logic [3:0]  count,
  output logic        busy,
  output logic        ovf,
  output logic        bad
);

  typedef enum logic [1:0] {IDLE, ADD, COMMIT} state_t;

  state_t      state_q;
  logic [2:0]  scan_sync_q, clear_sync_q;
  logic [15:0] total_q, work_q, addend_q;
  logic [3:0]  count_q;
  logic [1:0]  idx_q;
  logic        carry_q, busy_q, ovf_q, bad_q;

  logic        scan_p, clear_p;
  logic [15:0] price_d;
  logic        price_ok_d;
  logic [3:0]  dig_lsb;
  logic [4:0]  sum_d;
  logic [3:0]  digit_d;
  logic        carry_d;

  // Two flops for metastability, the third keeps last level for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_sync_q  <= 3'b000;
      clear_sync_q <= 3'b000;
    end else begin
      scan_sync_q  <= {scan_sync_q[1:0], scan};
      clear_sync_q <= {clear_sync_q[1:0], clear};
    end
  end

  assign scan_p  = scan_sync_q[1] & ~scan_sync_q[2];
  assign clear_p = clear_sync_q[1] & ~clear_sync_q[2];

  always_comb begin
    price_d    = 16'h0000;
    price_ok_d = 1'b1;
    case (upc)
      3'b000:  price_d = 16'h0125;
      3'b001:  price_d = 16'h0099;
      3'b010:  price_d = 16'h0450;
      3'b011:  price_d = 16'h1200;
      3'b100:  price_d = 16'h0005;
      3'b101:  price_d = 16'h2500;
      default: price_ok_d = 1'b0;
    endcase
  end

  assign dig_lsb = {idx_q, 2'b00};

  // Adding 6 mod 16 to a sum in 10..19 yields sum - 10.
  always_comb begin
    sum_d   = {1'b0, work_q[dig_lsb +: 4]} + {1'b0, addend_q[dig_lsb +: 4]} + {4'b0000, carry_q};
    digit_d = sum_d[3:0];
    carry_d = 1'b0;
    if (sum_d > 5'd9) begin
      digit_d = sum_d[3:0] + 4'd6;
      carry_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      total_q  <= 16'h0000;
      work_q   <= 16'h0000;
      addend_q <= 16'h0000;
      count_q  <= 4'd0;
      idx_q    <= 2'd0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      bad_q    <= 1'b0;
    end else if (clear_p) begin
      state_q <= IDLE;
      total_q <= 16'h0000;
      count_q <= 4'd0;
      idx_q   <= 2'd0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (scan_p) begin
            if (price_ok_d) begin
              addend_q <= price_d;
              work_q   <= total_q;
              carry_q  <= 1'b0;
              idx_q    <= 2'd0;
              bad_q    <= 1'b0;
              busy_q   <= 1'b1;
              state_q  <= ADD;
            end else begin
              bad_q <= 1'b1;
            end
          end
        end
        ADD: begin
          work_q[dig_lsb +: 4] <= digit_d;
          carry_q              <= carry_d;
          idx_q                <= idx_q + 2'd1;
          if (idx_q == 2'd3) state_q <= COMMIT;
        end
        COMMIT: begin
          if (carry_q) begin
            total_q <= 16'h9999;
            ovf_q   <= 1'b1;
          end else begin
            total_q <= work_q;
          end
          if (int'(count_q) < CNT_MAX) count_q <= count_q + 4'd1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign total_bcd = total_q;
  assign count     = count_q;
  assign busy      = busy_q;
  assign ovf       = ovf_q;
  assign bad       = bad_q;

endmodule

// File: tb/tb_checkout_tally.sv
// Bench for checkout_tally: directed scenarios plus random scans, compared
// against a decimal-arithmetic model through an expected-response queue.
`timescale 1ns/1ps
module tb_checkout_tally;

  localparam int CNT_MAX = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  upc = 3'b000;
  logic        scan = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] total_bcd;
  logic [3:0]  count;
  logic        busy, ovf, bad;

  checkout_tally #(.CNT_MAX(CNT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .upc(upc), .scan(scan), .clear(clear),
    .total_bcd(total_bcd), .count(count), .busy(busy), .ovf(ovf), .bad(bad)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model + scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  // Entry: {busy_len[25:22] (0 = any), ovf[21], bad[20], count[19:16], total[15:0]}
  logic [25:0] exp_q[$];
  int   price_tab[8] = '{125, 99, 450, 1200, 5, 2500, -1, -1};
  int   m_total = 0;
  int   m_count = 0;
  logic m_ovf = 1'b0;
  logic m_bad = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [25:0] pack_exp(input int blen);
    return {4'(blen), m_ovf, m_bad, 4'(m_count), to_bcd(m_total)};
  endfunction

  task automatic model_zero();
    m_total = 0; m_count = 0; m_ovf = 1'b0; m_bad = 1'b0;
  endtask

  // ---------------- monitor ----------------
  logic        mon_busy_prev = 1'b0;
  int          mon_blen = 0;
  logic [25:0] mon_e;

  always @(negedge clk) begin
    if (busy) mon_blen++;
    if (mon_busy_prev && !busy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_response: total 0x%0h count %0d with no expected entry at %0t",
                 total_bcd, count, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_total", 32'(total_bcd), 32'(mon_e[15:0]));
        check("resp_count", 32'(count), 32'(mon_e[19:16]));
        check("resp_bad",   32'(bad),   32'(mon_e[20]));
        check("resp_ovf",   32'(ovf),   32'(mon_e[21]));
        if (mon_e[25:22] != 4'd0) check("resp_busy_len", 32'(mon_blen), 32'(mon_e[25:22]));
      end
      mon_blen = 0;
    end
    mon_busy_prev = busy;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || exp_q.size() != 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle: busy %0b pending %0d after 200 cycles", busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_busy(input string name);
    int k = 0;
    while (!busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: busy 0 expected 1 within 20 cycles", name);
    end
  endtask

  task automatic do_scan(input logic [2:0] code, input int hold);
    int p;
    p = price_tab[code];
    upc  = code;
    scan = 1'b1;
    if (p >= 0) begin
      m_total = m_total + p;
      if (m_total > 9999) begin
        m_total = 9999;
        m_ovf   = 1'b1;
      end
      m_bad   = 1'b0;
      m_count = (m_count + 1 > CNT_MAX) ? CNT_MAX : m_count + 1;
      exp_q.push_back(pack_exp(5));
    end else begin
      m_bad = 1'b1;
    end
    tick(hold);
    scan = 1'b0;
    tick(4);
    if (p < 0) begin
      check("bad_set",       32'(bad),       32'(1));
      check("bad_busy",      32'(busy),      32'(0));
      check("bad_total",     32'(total_bcd), 32'(to_bcd(m_total)));
      check("bad_count",     32'(count),     32'(m_count));
    end
    wait_idle();
    tick(1);
  endtask

  task automatic check_zero(input string name);
    check({name, "_total"}, 32'(total_bcd), 32'(0));
    check({name, "_count"}, 32'(count),     32'(0));
    check({name, "_busy"},  32'(busy),      32'(0));
    check({name, "_ovf"},   32'(ovf),       32'(0));
    check({name, "_bad"},   32'(bad),       32'(0));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(2);
    clear = 1'b0;
    tick(4);
    model_zero();
    check_zero("clear_idle");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick(3);
    check_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // First add: latency of 8 edges and 5 busy cycles (checked by monitor).
    upc = 3'b000;
    scan = 1'b1;
    m_total = 125; m_count = 1;
    exp_q.push_back(pack_exp(5));
    repeat (7) @(posedge clk);
    #1 check("latency_before_e7", 32'(total_bcd), 32'(0));
    @(posedge clk);
    #1 check("latency_at_e7", 32'(total_bcd), 32'h0125);
    scan = 1'b0;
    tick(4);
    wait_idle();
    tick(1);

    // Carry from cents through dollars.
    do_scan(3'b001, 3);
    check("total_0224", 32'(total_bcd), 32'h0224);
    do_scan(3'b001, 2);
    check("total_0323", 32'(total_bcd), 32'h0323);
    check("count_3",    32'(count),     32'(3));

    // Overflow to 99.99 and stickiness.
    do_clear();
    repeat (4) do_scan(3'b101, 2);
    check("ovf_total", 32'(total_bcd), 32'h9999);
    check("ovf_flag",  32'(ovf),       32'(1));
    check("ovf_count", 32'(count),     32'(4));
    do_scan(3'b100, 1);
    check("ovf_keep", 32'(total_bcd), 32'h9999);

    // Invalid code, then a valid scan clears bad.
    do_clear();
    do_scan(3'b000, 2);
    do_scan(3'b111, 2);
    do_scan(3'b000, 2);
    check("bad_cleared", 32'(bad), 32'(0));

    // Second press while busy is dropped; a long hold yields one add.
    upc = 3'b010;
    scan = 1'b1;
    m_total = m_total + 450; m_count = m_count + 1;
    exp_q.push_back(pack_exp(5));
    tick(2);
    scan = 1'b0;
    wait_busy("busy_drop_wait");
    scan = 1'b1;
    tick(2);
    scan = 1'b0;
    tick(4);
    wait_idle();
    tick(10);
    check("drop_total", 32'(total_bcd), 32'h0700);
    do_scan(3'b100, 100);
    check("hold_total", 32'(total_bcd), 32'h0705);

    // Clear in the middle of an add: no commit afterward.
    upc = 3'b011;
    scan = 1'b1;
    tick(2);
    scan = 1'b0;
    wait_busy("clear_mid_wait");
    model_zero();
    exp_q.push_back(pack_exp(0));
    clear = 1'b1;
    tick(2);
    clear = 1'b0;
    tick(4);
    check_zero("clear_mid");
    tick(15);
    check_zero("no_commit");

    // Simultaneous scan and clear: clear wins.
    do_scan(3'b000, 2);
    upc = 3'b001;
    scan = 1'b1;
    clear = 1'b1;
    tick(2);
    scan = 1'b0;
    clear = 1'b0;
    tick(8);
    model_zero();
    check_zero("scan_clear");

    // Asynchronous reset mid-add.
    do_scan(3'b011, 2);
    upc = 3'b101;
    scan = 1'b1;
    tick(2);
    scan = 1'b0;
    wait_busy("reset_mid_wait");
    model_zero();
    exp_q.push_back(pack_exp(0));
    #2 rst_n = 1'b0;
    #1 check_zero("reset_mid");
    tick(3);
    rst_n = 1'b1;
    tick(4);
    check_zero("after_reset");

    // Random scans against the model.
    repeat (60) begin
      if ($urandom_range(0, 19) == 0) do_clear();
      else do_scan(3'($urandom_range(0, 7)), $urandom_range(1, 12));
      tick($urandom_range(0, 5));
    end
    check("rand_total", 32'(total_bcd), 32'(to_bcd(m_total)));
    check("rand_count", 32'(count),     32'(m_count));
    check("rand_ovf",   32'(ovf),       32'(m_ovf));

    wait_idle();
    tick(10);
    check("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
